// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that owns a shared FIFO write port and tracks its occupancy
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CAPACITY   = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_read,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic [15:0]                   stall_count,
  output logic                          underflow_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int OW = $clog2(CAPACITY + 1);
  localparam logic [OW-1:0] CAP = OW'(CAPACITY);
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]    r_ack;
  logic [IW-1:0]         r_gid;
  logic [IW-1:0]         r_ptr;
  logic [OW-1:0]         r_occ;
  logic [15:0]           r_stall;
  logic                  r_uf;
  logic [NUM_REQ-1:0]    w_elig;
  logic [IW-1:0]         w_sel;
  logic [IW-1:0]         w_idx;
  logic                  w_hit;
  logic                  w_full;
  logic                  w_grant;
  logic                  w_dec;
  logic                  w_stall;
  assign w_elig  = req & ~r_ack;
  assign w_full  = r_occ == CAP;
  assign w_grant = |w_elig && !w_full;
  assign w_dec   = fifo_read && r_occ != '0;
  assign w_stall = |w_elig && w_full;
  // scan producers starting at the round-robin pointer and pick the first eligible one
  always_comb begin
    w_hit = 1'b0;
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
      w_sel = (!w_hit && w_elig[w_idx]) ? w_idx : w_sel;
      w_hit = w_hit | w_elig[w_idx];
    end
  end
  // register the write strobe, data, ack and grant bookkeeping for the selected producer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_data  <= '0;
      r_ack   <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
    end else begin
      r_write <= w_grant;
      r_ack   <= w_grant ? NUM_REQ'(1) << w_sel : '0;
      r_data  <= w_grant ? req_data[w_sel*DATA_WIDTH +: DATA_WIDTH] : r_data;
      r_gid   <= w_grant ? w_sel : r_gid;
      r_ptr   <= w_grant ? ((w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1) : r_ptr;
    end
  end
  // track occupancy from grants and reads, count full-FIFO stalls and latch underflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ   <= '0;
      r_stall <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_occ   <= (w_grant && !w_dec) ? r_occ + 1'b1 : (!w_grant && w_dec) ? r_occ - 1'b1 : r_occ;
      r_stall <= (w_stall && r_stall != 16'hFFFF) ? r_stall + 1'b1 : r_stall;
      r_uf    <= r_uf | (fifo_read && r_occ == '0);
    end
  end
  assign fifo_write    = r_write;
  assign fifo_data     = r_data;
  assign ack           = r_ack;
  assign grant_id      = r_gid;
  assign occupancy     = r_occ;
  assign stall_count   = r_stall;
  assign underflow_err = r_uf;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and randomized checks of the FIFO write arbiter against a reference model
module tb_fifo_write_arbiter;
  localparam int CAP = 31;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_read;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic [4:0]  occupancy;
  logic [15:0] stall_count;
  logic        underflow_err;
  int n_checks = 0;
  int n_err = 0;
  int m_occ, m_ptr, m_stall, m_gid;
  logic m_wr, m_uf;
  logic [7:0] m_data;
  logic [3:0] m_ack;
  int rd_pct [4] = '{15, 60, 95, 45};

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .fifo_read(fifo_read),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .ack(ack), .grant_id(grant_id),
    .occupancy(occupancy), .stall_count(stall_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: one clock edge of the arbiter described by its rules, applied to the pre-edge inputs
  task automatic model_step();
    logic [3:0] e;
    int sel;
    bit full, g, d;
    if (reset) begin
      m_occ = 0; m_ptr = 0; m_stall = 0; m_gid = 0;
      m_wr = 0; m_uf = 0; m_data = 0; m_ack = 0;
      return;
    end
    e = req & ~m_ack;
    sel = -1;
    for (int k = 0; k < 4; k++)
      if (sel < 0 && e[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
    full = (m_occ == CAP);
    if (e != 0 && full && m_stall < 65535) m_stall++;
    g = (sel >= 0) && !full;
    d = fifo_read && m_occ > 0;
    if (fifo_read && m_occ == 0) m_uf = 1;
    m_occ = m_occ + int'(g) - int'(d);
    if (g) begin
      m_wr = 1;
      m_data = req_data[sel*8 +: 8];
      m_ack = 4'(1 << sel);
      m_gid = sel;
      m_ptr = (sel + 1) % 4;
    end else begin
      m_wr = 0;
      m_ack = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("m_write", 32'(fifo_write), 32'(m_wr));
    chk("m_ack", 32'(ack), 32'(m_ack));
    chk("m_gid", 32'(grant_id), m_gid);
    chk("m_occ", 32'(occupancy), m_occ);
    chk("m_stall", 32'(stall_count), m_stall);
    chk("m_uf", 32'(underflow_err), 32'(m_uf));
    if (m_wr) chk("m_data", 32'(fifo_data), 32'(m_data));
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; fifo_read = 1'b0;
    cycle();
    cycle();
    chk("rst_write", 32'(fifo_write), 0);
    chk("rst_data", 32'(fifo_data), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_uf", 32'(underflow_err), 0);
    reset = 1'b0;
    req = 4'b0100; req_data[23:16] = 8'hA1;
    cycle();
    chk("t1_write", 32'(fifo_write), 1);
    chk("t1_data", 32'(fifo_data), 32'hA1);
    chk("t1_ack", 32'(ack), 32'b0100);
    chk("t1_gid", 32'(grant_id), 2);
    chk("t1_occ", 32'(occupancy), 1);
    req = '0;
    cycle();
    chk("t1_idle_write", 32'(fifo_write), 0);
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 4'hF; req_data = 32'h13121110;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rr_write", 32'(fifo_write), 1);
      chk("rr_gid", 32'(grant_id), c % 4);
      chk("rr_data", 32'(fifo_data), 32'h10 + c % 4);
    end
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("single_ack", 32'(ack), (c % 2 == 0) ? 2 : 0);
    end
    chk("single_occ", 32'(occupancy), 5);
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 4'b0011;
    repeat (31) cycle();
    chk("fill_occ", 32'(occupancy), 31);
    req = '0;
    cycle();
    req = 4'b0001;
    repeat (4) begin
      cycle();
      chk("stall_write", 32'(fifo_write), 0);
    end
    chk("stall_cnt", 32'(stall_count), 4);
    chk("stall_occ", 32'(occupancy), 31);
    fifo_read = 1'b1;
    cycle();
    chk("rd_full_occ", 32'(occupancy), 30);
    chk("rd_full_write", 32'(fifo_write), 0);
    fifo_read = 1'b0;
    cycle();
    chk("regrant_write", 32'(fifo_write), 1);
    chk("regrant_occ", 32'(occupancy), 31);
    req = '0; fifo_read = 1'b1;
    cycle();
    chk("pre_both_occ", 32'(occupancy), 30);
    req = 4'b0001;
    cycle();
    chk("both_write", 32'(fifo_write), 1);
    chk("both_occ", 32'(occupancy), 30);
    req = '0;
    repeat (30) cycle();
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_uf", 32'(underflow_err), 0);
    cycle();
    chk("uf_flag", 32'(underflow_err), 1);
    chk("uf_occ", 32'(occupancy), 0);
    fifo_read = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 4'hF;
    repeat (7) cycle();
    chk("burst_occ", 32'(occupancy), 7);
    reset = 1'b1;
    cycle();
    chk("mid_rst_write", 32'(fifo_write), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_gid", 32'(grant_id), 0);
    chk("mid_rst_data", 32'(fifo_data), 0);
    reset = 1'b0;
    cycle();
    chk("restart_gid", 32'(grant_id), 0);
    chk("restart_ack", 32'(ack), 1);
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 500; n++) begin
        for (int i = 0; i < 4; i++) begin
          if (!(req[i] && !m_ack[i])) begin
            req[i] = ($urandom_range(0, 99) < 70);
            req_data[i*8 +: 8] = 8'($urandom);
          end
        end
        fifo_read = ($urandom_range(0, 99) < rd_pct[p]);
        reset = ($urandom_range(0, 299) == 0);
        cycle();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
